ifetch_unit: RTL

Instruction fetch stage placed directly downstream of the program counter. It takes the PC's current fetch address and return address, runs the instruction-memory read handshake, and delivers each fetched instruction with its PC+4 to decode through a registered IF/ID interface. It back-pressures the PC through `pc_hold`, which drives the PC's `ramfull` input. It buffers one instruction when decode stalls and discards in-flight fetches on a flush.

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: imem read handshake into a registered IF/ID stage, 1 cycle ihit->id_valid, one-entry skid.
// Back-pressures the PC through pc_hold; define IFETCH_PERF_EN to build the perf_fetches/perf_stalls counters.
module ifetch_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] imemaddr,
  input  logic [31:0] returnaddr,
  output logic        pc_hold,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        id_stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stalls
);

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc4;
  } ifid_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0] state_q, state_d;
  ifid_t      id_q, id_d;
  ifid_t      skid_q, skid_d;
  logic       id_valid_q, id_valid_d;
  word_t      drain_addr_q, drain_addr_d;
  logic       accept;

  assign accept = !id_valid_q || !id_stall;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    id_valid_d   = id_valid_q;
    skid_d       = skid_q;
    drain_addr_d = drain_addr_q;
    iREN         = 1'b0;
    iaddr        = imemaddr;
    pc_hold      = 1'b1;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        iREN = 1'b1;
        if (flush) begin
          // PC must load the redirect target even if the old request is still outstanding
          pc_hold    = 1'b0;
          id_valid_d = 1'b0;
          if (!ihit) begin
            drain_addr_d = imemaddr;
            state_d      = DRAIN;
          end
        end else if (ihit) begin
          pc_hold = 1'b0;
          if (accept) begin
            id_d       = '{instr: iload, pc4: returnaddr};
            id_valid_d = 1'b1;
          end else begin
            skid_d  = '{instr: iload, pc4: returnaddr};
            state_d = HOLD;
          end
        end else if (id_valid_q && !id_stall) begin
          id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (flush) begin
          skid_d     = '0;
          pc_hold    = 1'b0;
          id_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (accept) begin
          id_d       = skid_q;
          id_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        // The killed request still has to complete before a new address may be issued
        iREN  = 1'b1;
        iaddr = drain_addr_q;
        if (flush || (id_valid_q && !id_stall)) id_valid_d = 1'b0;
        if (ihit) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      id_q         <= '0;
      skid_q       <= '0;
      id_valid_q   <= 1'b0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      skid_q       <= skid_d;
      id_valid_q   <= id_valid_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_q.instr;
  assign id_pc4   = id_q.pc4;

`ifdef IFETCH_PERF_EN
  word_t perf_fetches_q, perf_stalls_q;
  logic  id_load;

  assign id_load = !flush && accept && ((state_q == FETCH && ihit) || state_q == HOLD);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetches_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (id_load) perf_fetches_q <= perf_fetches_q + 32'd1;
      if (pc_hold && state_q != IDLE) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule
